// File: rtl/rx_sample_arbiter.sv
// Round-robin serializer: captures per-receiver I/Q samples and emits them as I,Q word pairs.
// Build macro RX_OVF_COUNT_EN adds saturating 16-bit per-receiver overflow counters on ovf_count.
module rx_sample_arbiter #(
    parameter int NUM_RX     = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_RX-1:0]            rx_enable,
    input  logic [NUM_RX-1:0]            rx_strobe,
    input  logic [NUM_RX*DATA_WIDTH-1:0] rx_I,
    input  logic [NUM_RX*DATA_WIDTH-1:0] rx_Q,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [2:0]                   out_rx_idx,
    output logic                         out_iq,
    output logic [NUM_RX-1:0]            overflow,
    input  logic                         overflow_clr,
    output logic [NUM_RX*16-1:0]         ovf_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } state_t;

    state_t                  state_r;
    logic [NUM_RX-1:0]       pending_r;
    logic [NUM_RX-1:0]       overflow_r;
    logic [DATA_WIDTH-1:0]   hold_i_r [NUM_RX];
    logic [DATA_WIDTH-1:0]   hold_q_r [NUM_RX];
    logic [DATA_WIDTH-1:0]   q_buf_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [2:0]              last_r;
    logic [2:0]              out_rx_idx_r;
    logic                    out_valid_r;
    logic                    out_iq_r;

    logic                    found_s;
    logic                    grant_s;
    logic [2:0]              grant_idx_s;
    logic [DATA_WIDTH-1:0]   grant_i_s;
    logic [DATA_WIDTH-1:0]   grant_q_s;
    logic [NUM_RX-1:0]       grant_vec_s;
    logic [NUM_RX-1:0]       ovf_evt_s;

    // Round-robin search: walk candidates from farthest to nearest after last_r so the nearest hit wins
    always_comb begin
        int  cand;
        logic hit;
        cand        = 0;
        hit         = 1'b0;
        found_s     = 1'b0;
        grant_idx_s = 3'd0;
        grant_i_s   = '0;
        grant_q_s   = '0;
        for (int i = NUM_RX; i >= 1; i--) begin
            cand        = (int'(last_r) + i) % NUM_RX;
            hit         = pending_r[cand];
            found_s     = found_s | hit;
            grant_idx_s = hit ? 3'(cand) : grant_idx_s;
            grant_i_s   = hit ? hold_i_r[cand] : grant_i_s;
            grant_q_s   = hit ? hold_q_r[cand] : grant_q_s;
        end
        grant_s = found_s && (state_r == IDLE);
    end

    // Per-receiver grant decode and overflow event detection (a strobe coinciding with its own grant is not an overflow)
    always_comb begin
        grant_vec_s = '0;
        ovf_evt_s   = '0;
        for (int k = 0; k < NUM_RX; k++) begin
            grant_vec_s[k] = grant_s && (grant_idx_s == 3'(k));
            ovf_evt_s[k]   = rx_strobe[k] && rx_enable[k] && pending_r[k] && !grant_vec_s[k];
        end
    end

    // Sample capture, pending flags and sticky overflow flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_r  <= '0;
            overflow_r <= '0;
            for (int k = 0; k < NUM_RX; k++) begin
                hold_i_r[k] <= '0;
                hold_q_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                if (rx_enable[k] && rx_strobe[k]) begin
                    hold_i_r[k] <= rx_I[k*DATA_WIDTH +: DATA_WIDTH];
                    hold_q_r[k] <= rx_Q[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (!rx_enable[k]) begin
                    pending_r[k] <= 1'b0;
                end else if (rx_strobe[k]) begin
                    pending_r[k] <= 1'b1;
                end else if (grant_vec_s[k]) begin
                    pending_r[k] <= 1'b0;
                end
                if (ovf_evt_s[k]) begin
                    overflow_r[k] <= 1'b1;
                end else if (overflow_clr) begin
                    overflow_r[k] <= 1'b0;
                end
            end
        end
    end

    // Serializer FSM: grant a receiver, then present its I and Q words under the out_ready handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            q_buf_r      <= '0;
            out_iq_r     <= 1'b0;
            out_rx_idx_r <= 3'd0;
            last_r       <= 3'(NUM_RX - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        out_data_r   <= grant_i_s;
                        q_buf_r      <= grant_q_s;
                        out_iq_r     <= 1'b0;
                        out_rx_idx_r <= grant_idx_s;
                        out_valid_r  <= 1'b1;
                        last_r       <= grant_idx_s;
                        state_r      <= SEND_I;
                    end
                end
                SEND_I: begin
                    if (out_ready) begin
                        out_data_r <= q_buf_r;
                        out_iq_r   <= 1'b1;
                        state_r    <= SEND_Q;
                    end
                end
                SEND_Q: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_iq     = out_iq_r;
    assign out_rx_idx = out_rx_idx_r;
    assign overflow   = overflow_r;

`ifdef RX_OVF_COUNT_EN
    logic [NUM_RX*16-1:0] ovf_cnt_r;

    // Saturating overflow counters; a same-cycle overflow beats the clear and leaves the count at 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_r <= '0;
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                if (ovf_evt_s[k]) begin
                    if (overflow_clr) begin
                        ovf_cnt_r[k*16 +: 16] <= 16'd1;
                    end else if (ovf_cnt_r[k*16 +: 16] != 16'hFFFF) begin
                        ovf_cnt_r[k*16 +: 16] <= ovf_cnt_r[k*16 +: 16] + 16'd1;
                    end
                end else if (overflow_clr) begin
                    ovf_cnt_r[k*16 +: 16] <= 16'd0;
                end
            end
        end
    end

    assign ovf_count = ovf_cnt_r;
`else
    assign ovf_count = '0;
`endif

endmodule
